// File: rtl/i2s_rx_pkg.sv
// rtl/i2s_rx_pkg.sv - shared audio definitions: I2S channel and receiver state encodings
`timescale 1ns/1ps
package i2s_rx_pkg;

  // Word-select level that identifies each channel
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_e;

  // Receiver control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // disabled, partial word discarded
    ST_ARM  = 2'd1,  // enabled, waiting for the first word boundary
    ST_RUN  = 2'd2   // word-aligned, emitting samples
  } rx_state_e;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer for one asynchronous input bit
`timescale 1ns/1ps
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - oversampling I2S receiver producing left/right samples in the clk_i domain
`timescale 1ns/1ps
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int AUDIO_DW    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                sck_i,
  input  logic                ws_i,
  input  logic                sd_i,
  input  logic                err_clr_i,
  output logic [AUDIO_DW-1:0] l_data_o,
  output logic [AUDIO_DW-1:0] r_data_o,
  output logic                l_valid_o,
  output logic                r_valid_o,
  output logic                short_err_o
);

  localparam int CW = $clog2(AUDIO_DW + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(AUDIO_DW);

  logic                sck_s, ws_s, sd_s, sck_d;
  logic                sck_rise, boundary;
  logic                ws_q, ws_primed;
  rx_state_e           state_q, state_d;
  logic                capture_en, emit_en;
  logic [CW-1:0]       bit_cnt_q, n_bits;
  logic [AUDIO_DW-1:0] shift_q, shift_nxt, word_aligned, word_q;
  logic                evt_l_q, evt_r_q, short_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sck (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(sck_i), .q_o(sck_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ws  (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(ws_i),  .q_o(ws_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sd  (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(sd_i),  .q_o(sd_s));

  // ws_q starts from a reset value, so the first rise only primes it; a
  // boundary needs two real ws samples, otherwise a reset mid-right-word
  // would look like a boundary.
  assign sck_rise = sck_s & ~sck_d;
  assign boundary = sck_rise & ws_primed & (ws_s != ws_q);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: arm on enable, align on the first boundary, drop out when disabled
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_i) state_d = ST_ARM;
      ST_ARM:  if (boundary) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
    if (!en_i) state_d = ST_IDLE;
  end

  // FSM outputs: collect bits while enabled, emit words only once aligned
  always_comb begin
    capture_en = en_i && (state_q != ST_IDLE);
    emit_en    = en_i && (state_q == ST_RUN);
  end

  // Word assembly: include the current bit if there is room, then left-align
  always_comb begin
    shift_nxt = shift_q;
    n_bits    = CNT_FULL;
    if (bit_cnt_q < CNT_FULL) begin
      shift_nxt = {shift_q[AUDIO_DW-2:0], sd_s};
      n_bits    = bit_cnt_q + CW'(1);
    end
    word_aligned = shift_nxt << (CNT_FULL - n_bits);
  end

  // Edge detection, ws tracking and bit shifting on each sck rise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_d     <= 1'b0;
      ws_q      <= 1'b0;
      ws_primed <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      short_q   <= 1'b0;
      evt_l_q   <= 1'b0;
      evt_r_q   <= 1'b0;
    end else begin
      sck_d   <= sck_s;
      evt_l_q <= 1'b0;
      evt_r_q <= 1'b0;
      if (sck_rise) begin
        ws_q      <= ws_s;
        ws_primed <= 1'b1;
      end
      if (!capture_en) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else if (boundary) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
        if (emit_en) begin
          evt_l_q <= (ws_q == CH_LEFT);
          evt_r_q <= (ws_q == CH_RIGHT);
          word_q  <= word_aligned;
          short_q <= (n_bits < CNT_FULL);
        end
      end else if (sck_rise && (bit_cnt_q < CNT_FULL)) begin
        shift_q   <= shift_nxt;
        bit_cnt_q <= bit_cnt_q + CW'(1);
      end
    end
  end

  // Output registers: publish the completed word one cycle after the boundary
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      l_data_o    <= '0;
      r_data_o    <= '0;
      l_valid_o   <= 1'b0;
      r_valid_o   <= 1'b0;
      short_err_o <= 1'b0;
    end else begin
      l_valid_o <= evt_l_q;
      r_valid_o <= evt_r_q;
      if (evt_l_q) l_data_o <= word_q;
      if (evt_r_q) r_data_o <= word_q;
      if (err_clr_i) begin
        short_err_o <= 1'b0;
      end else if ((evt_l_q || evt_r_q) && short_q) begin
        short_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - self-checking bench for i2s_rx
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int DW   = 8;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0;
  logic          sck_i = 1'b0;
  logic          ws_i = 1'b0;
  logic          sd_i = 1'b0;
  logic          err_clr_i = 1'b0;
  logic [DW-1:0] l_data_o, r_data_o;
  logic          l_valid_o, r_valid_o, short_err_o;

  i2s_rx #(.AUDIO_DW(DW), .SYNC_STAGES(SYNC)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .sck_i(sck_i), .ws_i(ws_i), .sd_i(sd_i),
    .err_clr_i(err_clr_i), .l_data_o(l_data_o), .r_data_o(r_data_o),
    .l_valid_o(l_valid_o), .r_valid_o(r_valid_o), .short_err_o(short_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ch;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    int            nl;
    logic [15:0]   lv;
    int            nr;
    logic [15:0]   rv;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    logic          es;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_bnd = 0;
  logic ws_prev = 1'b0;
  logic alt_chk = 1'b0;
  logic last_ch = 1'b1;
  logic mon_ch;
  exp_t mon_e;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic ch, input logic [DW-1:0] d);
    exp_t t;
    t.ch   = ch;
    t.data = d;
    sb.push_back(t);
  endtask

  // One sck period, starting and ending at a clk negedge: 4 clk low, 4 clk high
  task automatic bit_period(input logic w, input logic d);
    sck_i = 1'b0;
    ws_i  = w;
    sd_i  = d;
    repeat (4) @(negedge clk);
    if (w != ws_prev) last_bnd = cyc;
    ws_prev = w;
    sck_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Bits hi..lo of a word, MSB first; ws flips to the next channel on the LSB
  task automatic send_bits(input logic ch, input logic nxt, input logic [15:0] val,
                           input int hi, input int lo);
    for (int i = hi; i >= lo; i--) bit_period((i == 0) ? nxt : ch, val[i]);
  endtask

  task automatic idle_check(input string name);
    repeat (6) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expected word
  always @(negedge clk) begin
    if (rst_ni && (l_valid_o || r_valid_o)) begin
      mon_ch = r_valid_o;
      check("one_valid", {31'd0, l_valid_o & r_valid_o}, 0);
      check("latency", cyc - last_bnd, SYNC + 2);
      if (alt_chk) check("alternate", {31'd0, mon_ch}, {31'd0, ~last_ch});
      last_ch = mon_ch;
      if (sb.size() == 0) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL unexpected_valid: got ch %0d data 0x%0h expected no pulse", mon_ch,
                 mon_ch ? r_data_o : l_data_o);
      end else begin
        mon_e = sb.pop_front();
        check("valid_ch", {31'd0, mon_ch}, {31'd0, mon_e.ch});
        check("valid_data", {24'd0, mon_ch ? r_data_o : l_data_o}, {24'd0, mon_e.data});
      end
    end
  end

  initial begin
    vecs[0] = '{8,  16'h00A5, 8,  16'h003C, 8'hA5, 8'h3C, 1'b0};
    vecs[1] = '{10, 16'h02B7, 10, 16'h03FF, 8'hAD, 8'hFF, 1'b0};
    vecs[2] = '{6,  16'h002D, 8,  16'h0081, 8'hB4, 8'h81, 1'b1};
    vecs[3] = '{8,  16'h0000, 8,  16'h00FF, 8'h00, 8'hFF, 1'b0};
    vecs[4] = '{1,  16'h0001, 1,  16'h0000, 8'h80, 8'h00, 1'b1};
    vecs[5] = '{8,  16'h007F, 7,  16'h0055, 8'h7F, 8'hAA, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_outputs", {13'd0, l_data_o, r_data_o, l_valid_o, r_valid_o, short_err_o}, 0);
    rst_ni = 1'b1;
    en_i   = 1'b1;

    // Priming right word: its boundary arms the receiver and is not emitted
    send_bits(1'b1, 1'b0, 16'h00C3, 7, 0);
    idle_check("arm_no_output");

    for (int i = 0; i < 6; i++) begin
      push_exp(1'b0, vecs[i].el);
      push_exp(1'b1, vecs[i].er);
      send_bits(1'b0, 1'b1, vecs[i].lv, vecs[i].nl - 1, 0);
      send_bits(1'b1, 1'b0, vecs[i].rv, vecs[i].nr - 1, 0);
      idle_check("vec_drain");
      check("vec_l_hold", {24'd0, l_data_o}, {24'd0, vecs[i].el});
      check("vec_r_hold", {24'd0, r_data_o}, {24'd0, vecs[i].er});
      check("vec_short", {31'd0, short_err_o}, {31'd0, vecs[i].es});
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      check("short_clear", {31'd0, short_err_o}, 0);
    end

    // Clear held across a short-word set: clear must win
    err_clr_i = 1'b1;
    push_exp(1'b0, 8'hFC);
    push_exp(1'b1, 8'h12);
    send_bits(1'b0, 1'b1, 16'h003F, 5, 0);
    send_bits(1'b1, 1'b0, 16'h0012, 7, 0);
    idle_check("clr_prio_drain");
    err_clr_i = 1'b0;
    @(negedge clk);
    check("clr_priority", {31'd0, short_err_o}, 0);

    // Enable dropped mid-word: that word is lost, the following words are clean
    send_bits(1'b0, 1'b1, 16'h00E7, 7, 5);
    en_i = 1'b0;
    send_bits(1'b0, 1'b1, 16'h00E7, 4, 3);
    en_i = 1'b1;
    send_bits(1'b0, 1'b1, 16'h00E7, 2, 0);
    idle_check("en_rearm_silent");
    push_exp(1'b1, 8'h5A);
    push_exp(1'b0, 8'hC6);
    send_bits(1'b1, 1'b0, 16'h005A, 7, 0);
    send_bits(1'b0, 1'b1, 16'h00C6, 7, 0);
    idle_check("en_rearm_drain");

    // Reset mid-right-word: outputs clear at once, partial word never emitted
    send_bits(1'b1, 1'b0, 16'h0099, 7, 4);
    rst_ni = 1'b0;
    #1;
    check("async_reset", {13'd0, l_data_o, r_data_o, l_valid_o, r_valid_o, short_err_o}, 0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    send_bits(1'b1, 1'b0, 16'h0099, 3, 0);
    idle_check("post_reset_silent");
    push_exp(1'b0, 8'h4E);
    push_exp(1'b1, 8'hB1);
    send_bits(1'b0, 1'b1, 16'h004E, 7, 0);
    send_bits(1'b1, 1'b0, 16'h00B1, 7, 0);
    idle_check("post_reset_drain");

    // Random frames: data, latency and strict L/R alternation
    alt_chk = 1'b1;
    last_ch = 1'b1;
    for (int f = 0; f < 100; f++) begin
      logic [15:0] lv, rv;
      lv = 16'($urandom_range(0, 255));
      rv = 16'($urandom_range(0, 255));
      push_exp(1'b0, lv[7:0]);
      push_exp(1'b1, rv[7:0]);
      send_bits(1'b0, 1'b1, lv, 7, 0);
      send_bits(1'b1, 1'b0, rv, 7, 0);
    end
    idle_check("random_drain");
    check("random_short", {31'd0, short_err_o}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 SHALL have parameter AUDIO_DW, default 8, giving the received sample width per channel.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on each serial input (minimum 2).
REQ-003 SHALL have port clk_i, input, 1 bit: system clock; the only clock in the block.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port en_i, input, 1 bit: receiver enable.
REQ-006 SHALL have port sck_i, input, 1 bit: I2S bit clock, asynchronous to clk_i.
REQ-007 SHALL have port ws_i, input, 1 bit: I2S word select (0 = left, 1 = right), asynchronous.
REQ-008 SHALL have port sd_i, input, 1 bit: I2S serial data, MSB first, asynchronous.
REQ-009 SHALL have port l_data_o, output, AUDIO_DW bits: last complete left sample.
REQ-010 SHALL have port r_data_o, output, AUDIO_DW bits: last complete right sample.
REQ-011 SHALL have port l_valid_o, output, 1 bit: one-cycle pulse when l_data_o updates.
REQ-012 SHALL have port r_valid_o, output, 1 bit: one-cycle pulse when r_data_o updates.
REQ-013 SHALL have port short_err_o, output, 1 bit: sticky flag, a word with fewer than AUDIO_DW bits was received.
REQ-014 SHALL have port err_clr_i, input, 1 bit: synchronous clear of short_err_o.

Function
REQ-015 SHALL synchronize sck_i, ws_i and sd_i through SYNC_STAGES flops each, then detect the sck rising edge by comparing against one further sck flop.
REQ-016 SHALL operate correctly when the sck_i frequency is at most clk_i/4, with each sck_i high and low phase lasting at least 2 clk_i periods.
REQ-017 SHALL, on each detected sck rise, sample the synchronized ws into ws_q and the synchronized sd into the current bit.
REQ-018 SHALL treat a sck rise at which the sampled ws differs from the previous ws_q as a word boundary: the bit sampled at that rise is the LSB of the old word.
REQ-019 SHALL implement a state machine with states IDLE (disabled), ARM (waiting for the first word boundary) and RUN.
REQ-020 SHALL transition IDLE->ARM when en_i=1, ARM->RUN at the first word boundary, and any state->IDLE when en_i=0.
REQ-021 SHALL, on entry to IDLE, discard any partial word.
REQ-022 SHALL, in ARM, emit no valid pulse and discard the partial word that precedes the first boundary.
REQ-023 SHALL, in RUN, shift bits in MSB-first while the bit counter is below AUDIO_DW.
REQ-024 SHALL ignore bits beyond AUDIO_DW, with the bit counter saturating.
REQ-025 SHALL, at each RUN word boundary, complete the word: a left word when the old ws_q=0, a right word when the old ws_q=1.
REQ-026 SHALL left-align a word of n<AUDIO_DW bits, zero-pad it, and set short_err_o.
REQ-027 SHALL reset the bit counter at each word boundary, with the next bit counted as the new word's MSB.
REQ-028 SHALL update l_data_o or r_data_o and pulse the matching valid in the clk_i cycle after the boundary sck rise is detected.
REQ-029 SHALL give a fixed latency of SYNC_STAGES+2 clk_i cycles from the sck_i pin rising edge to the valid pulse.
REQ-030 SHALL never assert l_valid_o and r_valid_o in the same cycle.
REQ-031 SHALL hold data outputs between pulses.
REQ-032 SHALL give err_clr_i priority over a simultaneous short-word set: short_err_o clears in that cycle.

Reset
REQ-033 SHALL, while rst_ni=0, asynchronously clear every flop: state=IDLE, synchronizers=0, ws_q=0, bit counter=0, shift register=0.
REQ-034 SHALL, while rst_ni=0, drive l_data_o=0, r_data_o=0, l_valid_o=0, r_valid_o=0 and short_err_o=0.
REQ-035 SHALL, after reset deasserts mid-frame, require a fresh word boundary (ARM) before any output.

Structure
REQ-036 SHALL place the I2S channel encoding (LEFT=0, RIGHT=1) and the state encoding in the shared audio package.
REQ-037 SHALL implement one sub-module, sync_ff (a SYNC_STAGES-deep synchronizer), instantiated three times.

Verification
REQ-038 SHALL cover: AUDIO_DW=8, sck=clk/8, standard I2S, L=0xA5, R=0x3C -> after the ARM frame, l_data_o=0xA5 then r_data_o=0x3C, with exactly one pulse each.
REQ-039 SHALL cover: 10-bit words L=0x2B7 -> l_data_o=0xAD (top 8 bits), short_err_o=0.
REQ-040 SHALL cover: 6-bit word L=0b101101 -> l_data_o=0xB4, short_err_o=1; err_clr_i pulse -> short_err_o=0.
REQ-041 SHALL cover: en_i dropped mid-word then raised -> no valid until a boundary has passed, then the next full word is correct.
REQ-042 SHALL cover: rst_ni asserted mid-frame -> all outputs 0 immediately; after release, the first partial word is not emitted.
REQ-043 SHALL cover: measured pin-edge-to-valid latency = SYNC_STAGES+2 clk_i cycles over 100 random frames, with the valid pulses alternating L/R.
